// File: rtl/sram_access_ctrl.sv
// Single-word SRAM access sequencer: turns client requests into active-low CE/UB/LB/OE/WE strobes.
// Optional macro SRAM_WRITE_TURNAROUND_EN adds one idle TURN cycle after every write.
module sram_access_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        busy,
  output logic        ack,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic [19:0] ADDR,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [15:0] Data_to_SRAM,
  output logic        sram_drive,
  input  logic [15:0] Data_from_SRAM
);

  localparam logic [3:0] LP_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
`ifdef SRAM_WRITE_TURNAROUND_EN
    S_DONE,
    S_TURN
`else
    S_DONE
`endif
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_we;
  logic [19:0] r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_be;
  logic [3:0]  r_count;
  logic [15:0] r_rdData;
  logic [15:0] w_mask;
  logic        w_lastAccess;

  assign w_mask       = {{8{r_be[1]}}, {8{r_be[0]}}};
  assign w_lastAccess = (r_state == S_ACCESS) && (r_count == 4'd0);
  assign ADDR         = r_addr;
  assign Data_to_SRAM = r_wdata;
  assign rd_data      = r_rdData;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Request capture, strobe-width counter and masked read-data register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_we     <= 1'b0;
      r_addr   <= 20'h00000;
      r_wdata  <= 16'h0000;
      r_be     <= 2'b00;
      r_count  <= 4'd0;
      r_rdData <= 16'h0000;
    end else begin
      if ((r_state == S_IDLE) && req) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
      if (r_state == S_SETUP) begin
        r_count <= LP_LOAD;
      end else if ((r_state == S_ACCESS) && (r_count != 4'd0)) begin
        r_count <= r_count - 4'd1;
      end
      if (w_lastAccess && !r_we) begin
        r_rdData <= Data_from_SRAM & w_mask;
      end
    end
  end

  // OE and WE are decoded from the same captured direction bit, so they can never be low together.
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    ack         = 1'b0;
    rd_valid    = 1'b0;
    CE          = 1'b1;
    UB          = 1'b1;
    LB          = 1'b1;
    OE          = 1'b1;
    WE          = 1'b1;
    sram_drive  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) w_nextState = S_SETUP;
      end
      S_SETUP: begin
        busy        = 1'b1;
        CE          = 1'b0;
        UB          = ~r_be[1];
        LB          = ~r_be[0];
        sram_drive  = r_we;
        w_nextState = S_ACCESS;
      end
      S_ACCESS: begin
        busy       = 1'b1;
        CE         = 1'b0;
        UB         = ~r_be[1];
        LB         = ~r_be[0];
        OE         = r_we;
        WE         = ~r_we;
        sram_drive = r_we;
        if (r_count == 4'd0) w_nextState = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        CE         = 1'b0;
        UB         = ~r_be[1];
        LB         = ~r_be[0];
        sram_drive = r_we;
        ack        = 1'b1;
        rd_valid   = ~r_we;
`ifdef SRAM_WRITE_TURNAROUND_EN
        w_nextState = r_we ? S_TURN : S_IDLE;
`else
        w_nextState = S_IDLE;
`endif
      end
`ifdef SRAM_WRITE_TURNAROUND_EN
      S_TURN: begin
        busy        = 1'b1;
        w_nextState = S_IDLE;
      end
`endif
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: instance A uses WAIT_CYCLES=1 with a small SRAM model,
// instance B uses WAIT_CYCLES=3 with a fixed data bus for back-to-back reads.
module tb_sram_access_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   illegalA = 0;
  int   illegalB = 0;

  logic        reqA = 1'b0, reqWeA = 1'b0;
  logic [19:0] reqAddrA = 20'h0;
  logic [15:0] reqWdataA = 16'h0;
  logic [1:0]  reqBeA = 2'b00;
  logic        busyA, ackA, rdValidA, ceA, ubA, lbA, oeA, weA, driveA;
  logic [15:0] rdDataA, dataToSramA, dataFromSramA;
  logic [19:0] addrA;
  logic [15:0] memA [16];

  logic        reqB = 1'b0, reqWeB = 1'b0;
  logic [19:0] reqAddrB = 20'h0;
  logic [15:0] reqWdataB = 16'h0;
  logic [1:0]  reqBeB = 2'b00;
  logic        busyB, ackB, rdValidB, ceB, ubB, lbB, oeB, weB, driveB;
  logic [15:0] rdDataB, dataToSramB, dataFromSramB;
  logic [19:0] addrB;

  always #5 clk = ~clk;

  sram_access_ctrl #(.WAIT_CYCLES(1)) dutA (
    .Clk(clk), .Reset(reset), .req(reqA), .req_we(reqWeA), .req_addr(reqAddrA),
    .req_wdata(reqWdataA), .req_be(reqBeA), .busy(busyA), .ack(ackA), .rd_data(rdDataA),
    .rd_valid(rdValidA), .ADDR(addrA), .CE(ceA), .UB(ubA), .LB(lbA), .OE(oeA), .WE(weA),
    .Data_to_SRAM(dataToSramA), .sram_drive(driveA), .Data_from_SRAM(dataFromSramA)
  );

  sram_access_ctrl #(.WAIT_CYCLES(3)) dutB (
    .Clk(clk), .Reset(reset), .req(reqB), .req_we(reqWeB), .req_addr(reqAddrB),
    .req_wdata(reqWdataB), .req_be(reqBeB), .busy(busyB), .ack(ackB), .rd_data(rdDataB),
    .rd_valid(rdValidB), .ADDR(addrB), .CE(ceB), .UB(ubB), .LB(lbB), .OE(oeB), .WE(weB),
    .Data_to_SRAM(dataToSramB), .sram_drive(driveB), .Data_from_SRAM(dataFromSramB)
  );

  // Tiny SRAM for instance A: byte-masked writes while WE is low, data out while OE is low.
  always @(posedge clk) begin
    if (!ceA && !weA) begin
      if (!ubA) memA[addrA[3:0]][15:8] <= dataToSramA[15:8];
      if (!lbA) memA[addrA[3:0]][7:0]  <= dataToSramA[7:0];
    end
  end
  assign dataFromSramA = oeA ? 16'h0000 : memA[addrA[3:0]];
  assign dataFromSramB = 16'hA5C3;

  // Watch both instances for the forbidden OE/WE overlap.
  always @(negedge clk) begin
    if (oeA === 1'b0 && weA === 1'b0) illegalA++;
    if (oeB === 1'b0 && weB === 1'b0) illegalB++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startA(input logic we, input logic [19:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be);
    reqA = 1'b1; reqWeA = we; reqAddrA = addr; reqWdataA = wdata; reqBeA = be;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    total++; if ({ceA, ubA, lbA, oeA, weA} !== 5'b11111) begin bad++; $display("[TB] FAIL reset_strobes got=%b exp=11111", {ceA, ubA, lbA, oeA, weA}); end
    total++; if ({busyA, ackA, rdValidA, driveA} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ctrl got=%b exp=0000", {busyA, ackA, rdValidA, driveA}); end
    total++; if (rdDataA !== 16'h0000) begin bad++; $display("[TB] FAIL reset_rddata got=%h exp=0000", rdDataA); end
    total++; if (addrA !== 20'h00000 || dataToSramA !== 16'h0000) begin bad++; $display("[TB] FAIL reset_addr_data got=%h/%h exp=00000/0000", addrA, dataToSramA); end
    total++; if ({busyB, ceB, oeB, weB} !== 4'b0111) begin bad++; $display("[TB] FAIL reset_b got=%b exp=0111", {busyB, ceB, oeB, weB}); end
  endtask

  task automatic test_write();
    startA(1'b1, 20'h00010, 16'hBEEF, 2'b11);
    tick(); reqA = 1'b0;
    total++; if ({busyA, ceA, driveA, weA, oeA} !== 5'b10111) begin bad++; $display("[TB] FAIL write_t1 got=%b exp=10111", {busyA, ceA, driveA, weA, oeA}); end
    total++; if (addrA !== 20'h00010 || dataToSramA !== 16'hBEEF) begin bad++; $display("[TB] FAIL write_t1_bus got=%h/%h exp=00010/beef", addrA, dataToSramA); end
    tick();
    total++; if ({weA, oeA, driveA, ubA, lbA} !== 5'b01100) begin bad++; $display("[TB] FAIL write_t2 got=%b exp=01100", {weA, oeA, driveA, ubA, lbA}); end
    tick();
    total++; if ({ackA, rdValidA, weA, driveA, ceA} !== 5'b10110) begin bad++; $display("[TB] FAIL write_t3 got=%b exp=10110", {ackA, rdValidA, weA, driveA, ceA}); end
    tick();
    total++; if ({busyA, driveA, ackA, ceA} !== 4'b0001) begin bad++; $display("[TB] FAIL write_t4 got=%b exp=0001", {busyA, driveA, ackA, ceA}); end
  endtask

  task automatic test_read();
    startA(1'b0, 20'h00010, 16'h0000, 2'b11);
    tick(); reqA = 1'b0;
    total++; if ({busyA, ceA, oeA, weA, driveA} !== 5'b10110) begin bad++; $display("[TB] FAIL read_t1 got=%b exp=10110", {busyA, ceA, oeA, weA, driveA}); end
    tick();
    total++; if ({oeA, weA, driveA} !== 3'b010) begin bad++; $display("[TB] FAIL read_t2 got=%b exp=010", {oeA, weA, driveA}); end
    tick();
    total++; if ({ackA, rdValidA, oeA} !== 3'b111 || rdDataA !== 16'hBEEF) begin bad++; $display("[TB] FAIL read_t3 got=%b/%h exp=111/beef", {ackA, rdValidA, oeA}, rdDataA); end
    tick();
    total++; if ({busyA, ackA, rdValidA} !== 3'b000 || rdDataA !== 16'hBEEF) begin bad++; $display("[TB] FAIL read_t4 got=%b/%h exp=000/beef", {busyA, ackA, rdValidA}, rdDataA); end
  endtask

  task automatic test_byte_enable_upper();
    startA(1'b0, 20'h00010, 16'h0000, 2'b10);
    tick(); reqA = 1'b0;
    tick();
    total++; if ({ubA, lbA, oeA} !== 3'b010) begin bad++; $display("[TB] FAIL be10_strobes got=%b exp=010", {ubA, lbA, oeA}); end
    tick();
    total++; if (ackA !== 1'b1 || rdDataA !== 16'hBE00) begin bad++; $display("[TB] FAIL be10_data got=%b/%h exp=1/be00", ackA, rdDataA); end
    tick();
  endtask

  task automatic test_hold_max_addr();
    startA(1'b1, 20'hFFFFF, 16'h1234, 2'b11);
    tick(); reqA = 1'b0;
    total++; if (addrA !== 20'hFFFFF) begin bad++; $display("[TB] FAIL maxaddr got=%h exp=fffff", addrA); end
    tick(); tick();
    total++; if (ackA !== 1'b1 || rdValidA !== 1'b0 || addrA !== 20'hFFFFF) begin bad++; $display("[TB] FAIL maxaddr_done got=%b%b/%h exp=10/fffff", ackA, rdValidA, addrA); end
    tick();
    total++; if (rdDataA !== 16'hBE00 || addrA !== 20'hFFFFF) begin bad++; $display("[TB] FAIL rddata_hold got=%h/%h exp=be00/fffff", rdDataA, addrA); end
  endtask

  task automatic test_reset_abort();
    int acks = 0;
    startA(1'b1, 20'h00021, 16'h5555, 2'b11);
    tick(); reqA = 1'b0;
    tick();
    total++; if (weA !== 1'b0) begin bad++; $display("[TB] FAIL abort_pre got=%b exp=0", weA); end
    reset = 1'b1;
    tick();
    total++; if ({weA, ceA, driveA, ackA, busyA} !== 5'b11000) begin bad++; $display("[TB] FAIL abort_post got=%b exp=11000", {weA, ceA, driveA, ackA, busyA}); end
    total++; if (rdDataA !== 16'h0000 || addrA !== 20'h00000) begin bad++; $display("[TB] FAIL abort_regs got=%h/%h exp=0000/00000", rdDataA, addrA); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ackA === 1'b1) acks++;
      tick();
    end
    total++; if (acks !== 0) begin bad++; $display("[TB] FAIL abort_noack got=%0d exp=0", acks); end
  endtask

  task automatic test_byte_enable_none();
    startA(1'b0, 20'h00010, 16'h0000, 2'b00);
    tick(); reqA = 1'b0;
    tick();
    total++; if ({ceA, ubA, lbA, oeA} !== 4'b0110) begin bad++; $display("[TB] FAIL be00_strobes got=%b exp=0110", {ceA, ubA, lbA, oeA}); end
    tick();
    total++; if (ackA !== 1'b1 || rdValidA !== 1'b1 || rdDataA !== 16'h0000) begin bad++; $display("[TB] FAIL be00_data got=%b%b/%h exp=11/0000", ackA, rdValidA, rdDataA); end
    tick();
  endtask

  task automatic test_back_to_back();
    int ackCount = 0, oeLow = 0, busyLow = 0, firstAck = 0, run = 0, badRuns = 0;
    reqB = 1'b1; reqWeB = 1'b0; reqAddrB = 20'h00005; reqBeB = 2'b11;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (ackB === 1'b1) begin
        ackCount++;
        if (firstAck == 0) firstAck = i;
      end
      if (busyB === 1'b0) busyLow++;
      if (oeB === 1'b0) begin
        oeLow++;
        run++;
      end else begin
        if (run != 0 && run != 3) badRuns++;
        run = 0;
      end
    end
    reqB = 1'b0;
    total++; if (ackCount !== 3) begin bad++; $display("[TB] FAIL b2b_acks got=%0d exp=3", ackCount); end
    total++; if (firstAck !== 5) begin bad++; $display("[TB] FAIL b2b_first_ack got=%0d exp=5", firstAck); end
    total++; if (oeLow !== 9 || badRuns !== 0) begin bad++; $display("[TB] FAIL b2b_oe got=%0d/%0d exp=9/0", oeLow, badRuns); end
    total++; if (busyLow !== 3) begin bad++; $display("[TB] FAIL b2b_gaps got=%0d exp=3", busyLow); end
    total++; if (rdDataB !== 16'hA5C3) begin bad++; $display("[TB] FAIL b2b_data got=%h exp=a5c3", rdDataB); end
    tick();
  endtask

  task automatic test_turnaround();
    bit gotAck = 1'b0;
    startA(1'b1, 20'h00032, 16'h1357, 2'b11);
    tick();
    reqWeA = 1'b0;
    tick(); tick();
    total++; if (ackA !== 1'b1) begin bad++; $display("[TB] FAIL turn_write_ack got=%b exp=1", ackA); end
    tick();
`ifdef SRAM_WRITE_TURNAROUND_EN
    total++; if ({busyA, ceA, ubA, lbA, oeA, weA, driveA} !== 7'b1111110) begin bad++; $display("[TB] FAIL turn_cycle got=%b exp=1111110", {busyA, ceA, ubA, lbA, oeA, weA, driveA}); end
    tick();
    total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL turn_idle got=%b exp=0", busyA); end
    tick();
    total++; if ({busyA, ceA, weA} !== 3'b101) begin bad++; $display("[TB] FAIL turn_read_setup got=%b exp=101", {busyA, ceA, weA}); end
`else
    total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL noturn_idle got=%b exp=0", busyA); end
    tick();
    total++; if ({busyA, ceA, weA} !== 3'b101) begin bad++; $display("[TB] FAIL noturn_read_setup got=%b exp=101", {busyA, ceA, weA}); end
`endif
    reqA = 1'b0;
    for (int i = 0; i < 10 && !gotAck; i++) begin
      tick();
      if (ackA === 1'b1) gotAck = 1'b1;
    end
    total++; if (!gotAck) begin bad++; $display("[TB] FAIL turn_read_timeout got=noack exp=ack"); end
    else begin
      total++; if (rdValidA !== 1'b1 || rdDataA !== 16'h1357) begin bad++; $display("[TB] FAIL turn_read_data got=%b/%h exp=1/1357", rdValidA, rdDataA); end
    end
    tick();
  endtask

  task automatic test_no_overlap();
    total++; if (illegalA !== 0 || illegalB !== 0) begin bad++; $display("[TB] FAIL oe_we_overlap got=%0d/%0d exp=0/0", illegalA, illegalB); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_byte_enable_upper();
    test_hold_max_addr();
    test_reset_abort();
    test_byte_enable_none();
    test_back_to_back();
    test_turnaround();
    test_no_overlap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Sequencer that sits directly upstream of the SRAM read-data path (Mem2IO).
- Converts single-word read/write requests from a client (CPU or frame-fetch engine) into properly timed active-low SRAM control strobes, address and write data.
- Captures read data into a registered result with a completion pulse.
- Guarantees the OE/WE combination the downstream read mux expects: a read is WE=1 with OE=0, and OE and WE are never low together.

Parameters:
- WAIT_CYCLES, 1, strobe (OE or WE) low time in clock cycles; legal range 1..15.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- req  in  1  request strobe; sampled only while busy=0
- req_we  in  1  1=write, 0=read
- req_addr  in  20  word address
- req_wdata  in  16  write data
- req_be  in  2  byte enables; bit1=upper byte, bit0=lower byte
- busy  out  1  access in progress; req ignored while high
- ack  out  1  one-cycle completion pulse
- rd_data  out  16  registered read result
- rd_valid  out  1  one-cycle pulse, coincident with ack on reads
- ADDR  out  20  SRAM address
- CE  out  1  chip enable, active low
- UB  out  1  upper byte enable, active low
- LB  out  1  lower byte enable, active low
- OE  out  1  output enable, active low
- WE  out  1  write enable, active low
- Data_to_SRAM  out  16  write data to the top-level tristate buffer
- sram_drive  out  1  tristate enable for Data_to_SRAM
- Data_from_SRAM  in  16  SRAM data bus input

Behaviour:
- Reset (sync, high) forces all outputs to these values at the next edge: CE=UB=LB=OE=WE=1, ADDR=0, Data_to_SRAM=0, sram_drive=0, busy=0, ack=0, rd_valid=0, rd_data=0; state=IDLE.
- Reset mid-access aborts the access. Strobes return inactive at the next edge and no ack is issued.
- States: IDLE, SETUP, ACCESS, DONE, plus TURN when the optional feature is compiled in.
- IDLE
  - busy=0; CE, UB, LB, OE, WE all 1; sram_drive=0; ADDR holds its last value.
  - req=1 at cycle T: capture we, addr, wdata and be; go to SETUP.
- SETUP (T+1)
  - busy=1; ADDR=captured address; CE=0; UB=~be[1], LB=~be[0]; OE=WE=1.
  - Write: sram_drive=1, Data_to_SRAM=wdata.
- ACCESS (T+2 .. T+1+WAIT_CYCLES)
  - Read: OE=0. Write: WE=0, sram_drive=1.
  - A down-counter loaded with WAIT_CYCLES-1 selects the last cycle.
  - Read: on the last ACCESS edge, rd_data <= Data_from_SRAM with bytes not enabled forced to 0x00.
- DONE (T+2+WAIT_CYCLES)
  - OE=WE=1; CE, UB, LB and ADDR held.
  - Write: sram_drive and Data_to_SRAM held for data hold time.
  - ack=1. Read: rd_valid=1, rd_data valid this cycle.
  - Next state is IDLE.
- Latency: ack arrives WAIT_CYCLES+2 cycles after the accept cycle. Throughput is one access per WAIT_CYCLES+3 cycles.
- Boundary conditions:
  - req while busy=1: ignored; no queueing.
  - req_be=00: full sequence runs with UB=LB=1; ack issued; a read returns rd_data=0x0000.
  - OE=0 and WE=0 in the same cycle is illegal and must never occur.
  - rd_data holds its value until the next completed read; writes do not alter it.
  - ADDR 0xFFFFF is legal; there is no wrap or increment.

Optional Feature:
- Macro: SRAM_WRITE_TURNAROUND_EN
- Defined: after DONE of a write, enter TURN for exactly one cycle. In TURN: busy=1; CE, UB, LB, OE, WE all 1; sram_drive=0. Then go to IDLE. Reads skip TURN. Write cost becomes WAIT_CYCLES+4 cycles.
- Undefined: DONE always goes directly to IDLE.

Test Plan:
- Reset held 2 cycles, then released: CE/UB/LB/OE/WE=1, busy=0, ack=0, rd_data=0x0000, sram_drive=0.
- WAIT_CYCLES=1, write addr 0x00010, data 0xBEEF, be=11, accepted at T: T+1 CE=0, sram_drive=1, WE=1; T+2 WE=0; T+3 ack=1, WE=1, drive still 1; T+4 busy=0, drive=0.
- WAIT_CYCLES=1, read addr 0x00010 with SRAM model returning 0xBEEF: T+2 OE=0, WE=1; T+3 ack=rd_valid=1, rd_data=0xBEEF; OE and WE never both 0.
- Read with be=10, model data 0xBEEF: UB=0, LB=1 during access; rd_data=0xBE00. Repeat with be=00: rd_data=0x0000, ack still issued.
- WAIT_CYCLES=3, req held high continuously: OE low for exactly 3 cycles; exactly one ack per 6 cycles; accesses do not overlap.
- Reset asserted at T+2 of a write: next cycle WE=CE=1, sram_drive=0, no ack. With SRAM_WRITE_TURNAROUND_EN defined, write then read: one TURN cycle with busy=1 and strobes inactive; read accepted one cycle later than in the non-macro build.
